// File: rtl/start_sprite_fetch.sv
// Start-banner sprite ROM read client: coordinate->address mapping, ROM latency alignment and "press start" blink FSM.
// Optional blink behaviour is built when START_BLINK_EN is defined; otherwise the banner is simply shown/hidden.
module start_sprite_fetch #(
    parameter int SPR_W        = 130,
    parameter int SPR_H        = 31,
    parameter int ADDR_W       = 12,
    parameter int PIX_W        = 4,
    parameter int X_POS        = 255,
    parameter int Y_POS        = 200,
    parameter int BLINK_FRAMES = 30,
    parameter int TRANSP_IDX   = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid_in,
    input  logic              frame_start,
    input  logic              show,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_valid_out,
    output logic              pix_hit,
    output logic [PIX_W-1:0]  pix_idx
);

    localparam logic [10:0]      X_LO      = 11'(X_POS);
    localparam logic [10:0]      X_HI      = 11'(X_POS + SPR_W);
    localparam logic [10:0]      Y_LO      = 11'(Y_POS);
    localparam logic [10:0]      Y_HI      = 11'(Y_POS + SPR_H);
    localparam logic [15:0]      SPR_W_VEC = 16'(SPR_W);
    localparam logic [PIX_W-1:0] TRANSP    = PIX_W'(TRANSP_IDX);

    typedef enum logic [1:0] {ST_HIDDEN, ST_ON, ST_OFF} state_t;

    state_t state_reg;
    logic   visible;

    assign visible = (state_reg == ST_ON);

`ifdef START_BLINK_EN
    localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt_reg;

    // Losing show wins over a coincident frame pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= ST_HIDDEN;
            frame_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_HIDDEN: begin
                    if (show) begin
                        state_reg     <= ST_ON;
                        frame_cnt_reg <= '0;
                    end
                end
                default: begin
                    if (!show) begin
                        state_reg <= ST_HIDDEN;
                    end else if (frame_start) begin
                        if (frame_cnt_reg == CNT_LAST) begin
                            state_reg     <= (state_reg == ST_ON) ? ST_OFF : ST_ON;
                            frame_cnt_reg <= '0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_HIDDEN;
        end else begin
            state_reg <= show ? ST_ON : ST_HIDDEN;
        end
    end
`endif

    logic              in_region;
    logic [9:0]        col_off;
    logic [9:0]        row_off;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] addr_next;

    assign in_region = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    assign col_off   = DrawX - X_LO[9:0];
    assign row_off   = DrawY - Y_LO[9:0];
    assign row_ext   = ADDR_W'(row_off);

    // Constant multiply by SPR_W as a sum of shifted rows (130 -> row<<7 + row<<1).
    always_comb begin
        addr_next = ADDR_W'(col_off);
        for (int i = 0; i < 16; i++) begin
            if (SPR_W_VEC[i]) begin
                addr_next = addr_next + (row_ext << i);
            end
        end
    end

    logic              s1_in_reg, s1_vis_reg, s1_valid_reg;
    logic              s2_in_reg, s2_vis_reg, s2_valid_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic              pix_valid_reg, pix_hit_reg;
    logic [PIX_W-1:0]  pix_idx_reg;
    logic              hit_next;

    assign hit_next = s2_in_reg & s2_vis_reg & s2_valid_reg & (rom_data != TRANSP);

    // Stage 2 flags line up with rom_data, which the ROM registers from rom_addr_reg.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_in_reg     <= 1'b0;
            s1_vis_reg    <= 1'b0;
            s1_valid_reg  <= 1'b0;
            rom_addr_reg  <= '0;
            s2_in_reg     <= 1'b0;
            s2_vis_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            pix_valid_reg <= 1'b0;
            pix_hit_reg   <= 1'b0;
            pix_idx_reg   <= '0;
        end else begin
            s1_in_reg     <= pix_valid_in & in_region;
            s1_vis_reg    <= pix_valid_in & visible;
            s1_valid_reg  <= pix_valid_in;
            rom_addr_reg  <= (pix_valid_in && in_region) ? addr_next : '0;
            s2_in_reg     <= s1_in_reg;
            s2_vis_reg    <= s1_vis_reg;
            s2_valid_reg  <= s1_valid_reg;
            pix_valid_reg <= s2_valid_reg;
            pix_hit_reg   <= hit_next;
            pix_idx_reg   <= hit_next ? rom_data : '0;
        end
    end

    assign rom_addr      = rom_addr_reg;
    assign pix_valid_out = pix_valid_reg;
    assign pix_hit       = pix_hit_reg;
    assign pix_idx       = pix_idx_reg;

endmodule

// File: doc/start_sprite_fetch.md
Name: start_sprite_fetch

Overview:
Read-side client of the start-banner sprite ROM (130x31 sprite, 4-bit palette indices, 1-cycle registered read).
- Maps VGA draw coordinates to a ROM address.
- Absorbs the ROM read latency.
- Outputs a pixel-aligned palette index plus an opaque-hit flag to the colour mapper.
- Contains the "press start" blink state machine, stepped by frame pulses.

Parameters:
SPR_W, 130, sprite width in pixels
SPR_H, 31, sprite height in pixels
ADDR_W, 12, ROM address width
PIX_W, 4, palette index width
X_POS, 255, sprite left column (screen x)
Y_POS, 200, sprite top row (screen y)
BLINK_FRAMES, 30, frames per blink phase
TRANSP_IDX, 0, palette index treated as transparent

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
pix_valid_in  in  1  DrawX/DrawY valid this cycle
frame_start  in  1  one-cycle pulse at start of each frame
show  in  1  level; banner enabled (game in start screen)
rom_addr  out  ADDR_W  address to sprite ROM
rom_data  in  PIX_W  ROM data, valid one cycle after rom_addr
pix_valid_out  out  1  pix_valid_in delayed 3 cycles
pix_hit  out  1  opaque, visible sprite pixel
pix_idx  out  PIX_W  palette index (0 when pix_hit=0)

Behaviour:
Reset (Reset_n low, asynchronous):
- All outputs are 0.
- FSM is HIDDEN, frame counter is 0, all pipeline valid bits are cleared.

Pipeline, total latency 3 cycles from input sample edge to outputs:
- Stage 1 (registered at edge E):
  - in_reg = (X_POS <= DrawX < X_POS+SPR_W) and (Y_POS <= DrawY < Y_POS+SPR_H).
  - rom_addr = (DrawY-Y_POS)*SPR_W + (DrawX-X_POS) when in_reg, else 0.
  - Multiply is done as shift-add (row<<7 + row<<1); result is 12 bits; range 0..4029.
  - in_reg, visible and pix_valid_in are captured alongside rom_addr.
- Stage 2 (edge E+1): the ROM registers rom_data. Flags advance one stage.
- Stage 3 (edge E+2, outputs valid after this edge):
  - pix_hit = in_reg & visible & valid & (rom_data != TRANSP_IDX).
  - pix_idx = rom_data when pix_hit, else 0.
  - pix_valid_out is the delayed valid.
- Region bounds: right and bottom edges are exclusive. DrawX = X_POS+SPR_W-1 is inside; X_POS+SPR_W is outside.
- pix_valid_in = 0: stage-1 flags are cleared; rom_addr holds 0.

Blink FSM, states HIDDEN, ON, OFF (visible = state==ON):
- HIDDEN: show=1 -> ON, counter cleared.
- ON or OFF: show=0 -> HIDDEN at the next edge. This overrides a simultaneous frame_start.
- ON or OFF with frame_start: if counter == BLINK_FRAMES-1, toggle ON<->OFF and clear counter; else increment counter.
- Counter width is ceil(log2(BLINK_FRAMES)); the counter never wraps past BLINK_FRAMES-1.
- Visibility is sampled at stage 1. A state change mid-frame therefore takes effect for pixels sampled after the change; there is no frame alignment.

Reset mid-operation: in-flight pixels are discarded; pix_valid_out = 0 until 3 cycles after the first valid input following reset release.

Optional Feature:
START_BLINK_EN
- Defined: FSM blinks as described.
- Undefined: OFF state and frame counter are not built. FSM is HIDDEN <-> ON only, driven solely by show; frame_start is ignored.

Test Plan:
1. show=1, DrawX=255, DrawY=200, valid=1 -> rom_addr=0 after 1 edge. DrawX=384, DrawY=230 -> rom_addr=4029. DrawX=385, DrawY=230 -> rom_addr=0, and 3 cycles later pix_hit=0.
2. In-region pixel with ROM model returning 5 -> 3 edges after input, pix_valid_out=1, pix_hit=1, pix_idx=5. ROM returning 0 -> pix_hit=0, pix_idx=0.
3. Streaming back-to-back coordinates DrawX=250..390 on row 210 -> pix_hit high for exactly 130 consecutive output cycles. pix_idx sequence matches ROM addresses 1300..1429.
4. START_BLINK_EN defined, show=1, 30 frame_start pulses -> visible drops after the 30th; 30 more -> visible again. show=0 coincident with frame_start -> HIDDEN.
5. START_BLINK_EN undefined, show=1, 100 frame_start pulses -> pix_hit for opaque in-region pixels never drops.
6. Reset_n pulsed low mid-stream (asynchronously, between edges) -> outputs 0 immediately, FSM HIDDEN. After release with show=1, first pix_valid_out appears exactly 3 edges after the first valid input.
